// File: rtl/spart_tx_packer_if.sv
`timescale 1ns/1ps
// Bus bundle for spart_tx_packer: CPU nibble writes, packet start request and
// serial-line status. The master drives requests and the slave (packer) reports status.
interface spart_tx_packer_if;
   logic        we;
   logic [2:0]  addr;
   logic [15:0] data_in;
   logic        start;
   logic        busy;
   logic        done;
   logic        txd;

   modport master (output we, addr, data_in, start, input busy, done, txd);
   modport slave  (input we, addr, data_in, start, output busy, done, txd);
endinterface

// File: rtl/spart_tx_packer.sv
`timescale 1ns/1ps
// Packs 15 CPU-written nibbles into {index, nibble} bytes plus an F0 terminator and
// sends them as 8N1 serial frames. Optional SPART_TX_CHECKSUM_EN adds an {E, XOR} byte.
module spart_tx_packer #(
   parameter logic [7:0] BAUD_DIV = 8'hA2
) (
   input  logic             clk,
   input  logic             rst_n,
   spart_tx_packer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START_BIT,
      DATA_BITS,
      STOP_BIT,
      FINISH
   } state_t;

   // Inter-frame stop bits end one clock early; the following LOAD clock keeps the line high.
   localparam logic [7:0] STOP_GAP = (BAUD_DIV == 8'd0) ? 8'd0 : BAUD_DIV - 8'd1;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_nib [15];
   logic [3:0]  r_idx;
   logic [7:0]  r_cnt;
   logic [7:0]  r_shift;
   logic [2:0]  r_bit;
   logic        r_last;
   logic        r_armed;
   logic        w_bit_end;
   logic        w_is_term;
   logic [7:0]  w_byte;
`ifdef SPART_TX_CHECKSUM_EN
   logic        r_chk_done;
   logic [3:0]  w_chk;

   always_comb begin
      w_chk = '0;
      for (int unsigned i = 0; i < 15; i++) w_chk = w_chk ^ r_nib[i];
   end
`endif

   assign w_bit_end = (r_cnt == BAUD_DIV);

   always_comb begin
      w_byte    = 8'hF0;
      w_is_term = 1'b0;
      if (r_idx != 4'd15) begin
         w_byte = {r_idx, r_nib[r_idx]};
      end else begin
`ifdef SPART_TX_CHECKSUM_EN
         w_byte    = r_chk_done ? 8'hF0 : {4'hE, w_chk};
         w_is_term = r_chk_done;
`else
         w_is_term = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      bus.busy = (r_state != IDLE);
      bus.done = (r_state == FINISH);
      bus.txd  = 1'b1;
      case (r_state)
         IDLE:      if (bus.start && r_armed) w_next = LOAD;
         LOAD:      w_next = START_BIT;
         START_BIT: begin
            bus.txd = 1'b0;
            if (w_bit_end) w_next = DATA_BITS;
         end
         DATA_BITS: begin
            bus.txd = r_shift[0];
            if (w_bit_end && r_bit == 3'd7) w_next = STOP_BIT;
         end
         STOP_BIT: begin
            if (r_last) begin
               if (w_bit_end) w_next = FINISH;
            end else if (r_cnt == STOP_GAP) begin
               w_next = LOAD;
            end
         end
         FINISH:    w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 15; i++) r_nib[i] <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_shift <= '0;
         r_bit   <= '0;
         r_last  <= 1'b0;
         r_armed <= 1'b0;
`ifdef SPART_TX_CHECKSUM_EN
         r_chk_done <= 1'b0;
`endif
      end else begin
         r_armed <= 1'b1;
         if (bus.we && r_state == IDLE) begin
            case (bus.addr)
               3'd1: r_nib[0] <= bus.data_in[3:0];
               3'd2: begin
                  r_nib[1] <= bus.data_in[15:12];
                  r_nib[2] <= bus.data_in[11:8];
                  r_nib[3] <= bus.data_in[7:4];
                  r_nib[4] <= bus.data_in[3:0];
               end
               3'd3: begin
                  r_nib[5] <= bus.data_in[15:12];
                  r_nib[6] <= bus.data_in[11:8];
                  r_nib[7] <= bus.data_in[7:4];
                  r_nib[8] <= bus.data_in[3:0];
               end
               3'd4: begin
                  r_nib[9]  <= bus.data_in[15:12];
                  r_nib[10] <= bus.data_in[11:8];
                  r_nib[11] <= bus.data_in[7:4];
                  r_nib[12] <= bus.data_in[3:0];
               end
               3'd5: begin
                  r_nib[13] <= bus.data_in[7:4];
                  r_nib[14] <= bus.data_in[3:0];
               end
               default: ;
            endcase
         end
         case (r_state)
            IDLE: begin
               r_idx  <= '0;
               r_cnt  <= '0;
               r_last <= 1'b0;
`ifdef SPART_TX_CHECKSUM_EN
               r_chk_done <= 1'b0;
`endif
            end
            LOAD: begin
               r_shift <= w_byte;
               r_last  <= w_is_term;
               r_cnt   <= '0;
               r_bit   <= '0;
               // Index saturates at 15; the checksum build uses a flag for its extra byte.
               if (r_idx != 4'd15) r_idx <= r_idx + 4'd1;
`ifdef SPART_TX_CHECKSUM_EN
               else r_chk_done <= 1'b1;
`endif
            end
            START_BIT: r_cnt <= w_bit_end ? '0 : r_cnt + 8'd1;
            DATA_BITS: begin
               r_cnt <= w_bit_end ? '0 : r_cnt + 8'd1;
               if (w_bit_end) begin
                  r_shift <= r_shift >> 1;
                  r_bit   <= r_bit + 3'd1;
               end
            end
            STOP_BIT:  r_cnt <= r_cnt + 8'd1;
            FINISH:    r_cnt <= '0;
            default:   r_cnt <= '0;
         endcase
      end
   end

endmodule
